// File: rtl/axis_bram_loader.sv
// AXI-Stream slave that unpacks 9-lane direction pixels into nine BRAM write ports,
// one frame of DEPTH beats per start pulse, flagging malformed frames.
module axis_bram_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                       s00_axis_aclk,
    input  logic                       s00_axis_areset,
    input  logic                       start,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic [9*DATA_WIDTH-1:0]    s00_axis_tdata,
    input  logic [9*DATA_WIDTH/8-1:0]  s00_axis_tstrb,
    input  logic                       s00_axis_tlast,
    output logic                       write_en,
    output logic [ADDRESS_WIDTH-1:0]   write_addr,
    output logic [DATA_WIDTH-1:0]      n_o,
    output logic [DATA_WIDTH-1:0]      null_o,
    output logic [DATA_WIDTH-1:0]      ne_o,
    output logic [DATA_WIDTH-1:0]      e_o,
    output logic [DATA_WIDTH-1:0]      se_o,
    output logic [DATA_WIDTH-1:0]      s_o,
    output logic [DATA_WIDTH-1:0]      sw_o,
    output logic [DATA_WIDTH-1:0]      w_o,
    output logic [DATA_WIDTH-1:0]      nw_o,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       frame_error
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]   cnt_q;
    logic                       accept_p0;
    logic                       at_last_p0;
    logic                       strb_ok_p0;
    logic                       start_p0;
    logic                       wr_vld_p1;
    logic [ADDRESS_WIDTH-1:0]   wr_addr_p1;
    logic [DATA_WIDTH-1:0]      lane_p1 [9];

    assign start_p0   = (state_q == IDLE) && start;
    assign accept_p0  = (state_q == RECV) && s00_axis_tvalid;
    assign at_last_p0 = (cnt_q == LAST_IDX);
    assign strb_ok_p0 = &s00_axis_tstrb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RECV;
            RECV:    if (s00_axis_tvalid) begin
                         if (s00_axis_tlast)  state_d = DONE;
                         else if (at_last_p0) state_d = DRAIN;
                     end
            DRAIN:   if (s00_axis_tvalid && s00_axis_tlast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_error <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_p0) begin
                cnt_q       <= '0;
                frame_error <= 1'b0;
            end else if (accept_p0) begin
                // Counter saturates at the last pixel so an overlong frame never wraps.
                if (!s00_axis_tlast && !at_last_p0)
                    cnt_q <= cnt_q + ADDRESS_WIDTH'(1);
                if ((s00_axis_tlast != at_last_p0) || !strb_ok_p0)
                    frame_error <= 1'b1;
            end
        end
    end

    // p0 -> p1: accepted beat becomes a BRAM write one cycle later
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            for (int i = 0; i < 9; i++) lane_p1[i] <= '0;
        end else begin
            wr_vld_p1 <= accept_p0;
            if (accept_p0) begin
                wr_addr_p1 <= cnt_q;
                for (int i = 0; i < 9; i++)
                    lane_p1[i] <= s00_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign s00_axis_tready = (state_q == RECV) || (state_q == DRAIN);
    assign busy            = (state_q != IDLE);
    assign frame_done      = (state_q == DONE);
    assign write_en        = wr_vld_p1;
    assign write_addr      = wr_addr_p1;
    assign nw_o            = lane_p1[0];
    assign w_o             = lane_p1[1];
    assign sw_o            = lane_p1[2];
    assign s_o             = lane_p1[3];
    assign se_o            = lane_p1[4];
    assign e_o             = lane_p1[5];
    assign ne_o            = lane_p1[6];
    assign n_o             = lane_p1[7];
    assign null_o          = lane_p1[8];

endmodule

// File: doc/axis_bram_loader.md
AXIS_BRAM_LOADER -- requirements
Module: axis_bram_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one direction population.
REQ-002 Parameter DEPTH, default 2500: pixels per frame, i.e. beats per AXI-Stream packet.
REQ-003 Parameter ADDRESS_WIDTH, default 12: BRAM write-address width; DEPTH SHALL be ≤ 2^ADDRESS_WIDTH.
REQ-004 s00_axis_aclk  in  1  the only clock; all logic SHALL be rising-edge.
REQ-005 s00_axis_areset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that arms reception of one frame.
REQ-007 s00_axis_tvalid  in  1  slave-side stream valid.
REQ-008 s00_axis_tready  out  1  slave-side stream ready.
REQ-009 s00_axis_tdata  in  144  one pixel, packed {null,n,ne,e,se,s,sw,w,nw}; null occupies [143:128] and nw occupies [15:0].
REQ-010 s00_axis_tstrb  in  18  byte strobes; not used for data, all-ones expected.
REQ-011 s00_axis_tlast  in  1  last beat of a frame.
REQ-012 write_en  out  1  BRAM write enable, common to all nine banks.
REQ-013 write_addr  out  ADDRESS_WIDTH  BRAM write address (pixel index).
REQ-014 n_o, null_o, ne_o, e_o, se_o, s_o, sw_o, w_o, nw_o  out  16 each  per-bank write data.
REQ-015 busy  out  1  high from the state after start until the return to IDLE.
REQ-016 frame_done  out  1  one-cycle pulse at the end of every frame.
REQ-017 frame_error  out  1  sticky flag for a tlast position or tstrb violation; cleared by start or reset.

Function
REQ-018 The FSM SHALL have four states: IDLE, RECV, DRAIN, DONE.
REQ-019 IDLE SHALL go to RECV on start=1; start outside IDLE SHALL be ignored.
REQ-020 s00_axis_tready SHALL be 1 exactly in RECV and DRAIN (a Moore output, independent of tvalid).
REQ-021 A beat SHALL be accepted only on a cycle with tvalid=1 and tready=1; tvalid without tready SHALL change nothing.
REQ-022 Each accepted RECV beat SHALL produce, on the next clock edge, write_en=1, write_addr=beat index, and the nine data outputs split per REQ-009.
REQ-023 write_en SHALL be 0 on every cycle that does not follow an accepted RECV beat; data outputs SHALL hold their last value.
REQ-024 The beat counter SHALL start at 0 on entry to RECV and increment by 1 per accepted beat; it SHALL never exceed DEPTH-1 (no wrap-around).
REQ-025 Beat DEPTH-1 with tlast=1: write the beat, go to DONE, no error.
REQ-026 Any beat below DEPTH-1 with tlast=1: write the beat, set frame_error, go to DONE (short frame).
REQ-027 Beat DEPTH-1 with tlast=0: write the beat, set frame_error, go to DRAIN.
REQ-028 DRAIN SHALL accept and discard beats with write_en=0, and go to DONE on the accepted beat with tlast=1.
REQ-029 An accepted RECV beat with tstrb not all-ones SHALL still be written, and SHALL set frame_error.
REQ-030 DONE SHALL last exactly one cycle, assert frame_done=1 during it, then go to IDLE.
REQ-031 busy SHALL be 1 in RECV, DRAIN and DONE, and 0 in IDLE.
REQ-032 Gaps in tvalid SHALL be tolerated without a limit; the counter and state hold during them.
REQ-033 start in IDLE SHALL clear frame_error on the same edge that enters RECV.

Reset
REQ-034 Asserting s00_axis_areset SHALL immediately set: state=IDLE, counter=0, tready=0, write_en=0, write_addr=0, all data outputs=0, busy=0, frame_done=0, frame_error=0.
REQ-035 Reset mid-frame SHALL abandon the frame; the next frame SHALL require a new start and SHALL write from address 0.
REQ-036 Releasing reset SHALL NOT by itself start reception.

Verification
REQ-037 Nominal: start, then 2500 back-to-back beats with tdata=pixel index replicated ×9 and tlast on beat 2499 -> 2500 write_en pulses at addresses 0..2499, each one cycle after its beat; frame_done once; frame_error=0.
REQ-038 Throttled: tvalid toggles randomly at 50% -> identical write sequence; no duplicated or skipped address.
REQ-039 Short frame: tlast on beat 99 -> 100 writes (addresses 0..99); frame_error=1; frame_done pulse; busy=0 afterwards.
REQ-040 Long frame: tlast on beat 2509 -> writes at addresses 0..2499 only; 10 beats drained with write_en=0; frame_error=1; frame_done after beat 2509.
REQ-041 Reset at beat 1234, then start plus a full frame -> all outputs 0 during reset; the new frame writes from address 0; frame_error=0.
REQ-042 Lane mapping: tdata=0x9999_8888_7777_6666_5555_4444_3333_2222_1111 -> null_o=0x9999, n_o=0x8888, ne_o=0x7777, e_o=0x6666, se_o=0x5555, s_o=0x4444, sw_o=0x3333, w_o=0x2222, nw_o=0x1111.
